// File: rtl/rx_ip_pkg.sv
// Shared constants and helpers for the receive-side IPv4 header analyser.
package rx_ip_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] IP_VERSION   = 4'd4;
  localparam logic [3:0] IP_IHL       = 4'd5;
  localparam logic [3:0] IP_HDR_WORDS = 4'd5;
  localparam logic [7:0] IP_PROTO_UDP = 8'h11;
  localparam logic [15:0] CSUM_OK     = 16'hFFFF;

  // Word index (counted from the sop word = 0) carrying each header field
  localparam logic [3:0] WIDX_VER_LEN = 4'd0;
  localparam logic [3:0] WIDX_PROTO   = 4'd2;
  localparam logic [3:0] WIDX_SRC_IP  = 4'd3;
  localparam logic [3:0] WIDX_DST_IP  = 4'd4;
  localparam logic [3:0] WIDX_MAX     = 4'd15;

  // One's-complement 16-bit add with end-around carry; never overflows again
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_hdr_csum.sv
// One's-complement accumulator over the IPv4 header halfwords.
// clr_i restarts the sum with the current word; sum_o/ok_o describe the
// sum including the word presented this cycle.
module ip_hdr_csum
  import rx_ip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [15:0] hi_i,
  input  logic [15:0] lo_i,
  output logic [15:0] sum_o,
  output logic        ok_o
);

  logic [15:0] acc_q;
  logic [15:0] acc_d;
  logic [15:0] base_s;

  // Next accumulator value: restart on sop, otherwise add both halfwords
  always_comb begin
    base_s = acc_q;
    acc_d  = acc_q;
    if (clr_i) begin
      base_s = 16'd0;
    end else begin
      base_s = acc_q;
    end
    if (add_i) begin
      acc_d = csum_add(csum_add(base_s, hi_i), lo_i);
    end else if (clr_i) begin
      acc_d = 16'd0;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 16'd0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign sum_o = acc_d;
  assign ok_o  = (acc_d == CSUM_OK);

endmodule

// File: rtl/rx_ip_analy.sv
// Receive-side IPv4 header analyser: strips the 5-word header, forwards the
// payload one cycle later and raises registered per-packet error flags.
// Build option: define RX_IP_PROTO_CHK_EN to also flag protocol != UDP in
// flag_type_err (evaluated on word 2 and OR-ed with the word-0 result).
module rx_ip_analy
  import rx_ip_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] cfg_ip_local,
  input  logic [DATA_W-1:0] cfg_ip_pc,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic [1:0]        din_mty,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic [1:0]        dout_mty,
  output logic              flag_type_err,
  output logic              flag_len_err,
  output logic              flag_sum_err,
  output logic              flag_ip_local_err,
  output logic              flag_ip_pc_err
);

  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_s;
  logic [15:0] tot_len_q, tot_len_d;
  logic [15:0] tot_len_s;
  logic [15:0] bytes_s;
  logic        fwd_s;
  logic        csum_clr_s;
  logic        csum_add_s;
  logic [15:0] csum_sum_s;
  logic        csum_ok_s;

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              dout_sop_q, dout_sop_d;
  logic              dout_eop_q, dout_eop_d;
  logic [1:0]        dout_mty_q, dout_mty_d;
  logic              type_err_q, type_err_d;
  logic              len_err_q, len_err_d;
  logic              sum_err_q, sum_err_d;
  logic              local_err_q, local_err_d;
  logic              pc_err_q, pc_err_d;

  // Index of the current word: the sop word is always index 0
  always_comb begin
    if (din_vld && din_sop) begin
      idx_s = 4'd0;
    end else begin
      idx_s = cnt_q;
    end
  end

  // Word counter: points at the index of the next word, saturating at 15
  always_comb begin
    cnt_d = cnt_q;
    if (din_vld) begin
      if (din_sop) begin
        cnt_d = 4'd1;
      end else if (cnt_q == WIDX_MAX) begin
        cnt_d = WIDX_MAX;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign fwd_s      = din_vld && (idx_s >= IP_HDR_WORDS);
  assign csum_clr_s = din_vld && din_sop;
  assign csum_add_s = din_vld && (idx_s < IP_HDR_WORDS);

  ip_hdr_csum u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (csum_clr_s),
    .add_i (csum_add_s),
    .hi_i  (din[31:16]),
    .lo_i  (din[15:0]),
    .sum_o (csum_sum_s),
    .ok_o  (csum_ok_s)
  );

  // Total length comes from the current word when the packet is one word long
  always_comb begin
    tot_len_d = tot_len_q;
    if (din_vld && (idx_s == WIDX_VER_LEN)) begin
      tot_len_s = din[15:0];
      tot_len_d = din[15:0];
    end else begin
      tot_len_s = tot_len_q;
      tot_len_d = tot_len_q;
    end
    bytes_s = (({12'd0, idx_s} + 16'd1) << 2) - {14'd0, din_mty};
  end

  // Payload path: forward words at index >= 5, hold data across gaps
  always_comb begin
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    dout_sop_d = 1'b0;
    dout_eop_d = 1'b0;
    dout_mty_d = 2'd0;
    if (fwd_s) begin
      dout_d     = din;
      dout_vld_d = 1'b1;
      dout_sop_d = (idx_s == IP_HDR_WORDS);
      dout_eop_d = din_eop;
      if (din_eop) begin
        dout_mty_d = din_mty;
      end else begin
        dout_mty_d = 2'd0;
      end
    end else begin
      dout_d = dout_q;
    end
  end

  // Flags: each one changes only on the word that decides it
  always_comb begin
    type_err_d  = type_err_q;
    len_err_d   = len_err_q;
    sum_err_d   = sum_err_q;
    local_err_d = local_err_q;
    pc_err_d    = pc_err_q;
    if (din_vld) begin
      case (idx_s)
        WIDX_VER_LEN: type_err_d = (din[31:28] != IP_VERSION) || (din[27:24] != IP_IHL);
`ifdef RX_IP_PROTO_CHK_EN
        WIDX_PROTO:   type_err_d = type_err_q || (din[23:16] != IP_PROTO_UDP);
`endif
        WIDX_SRC_IP:  pc_err_d = (din != cfg_ip_pc);
        WIDX_DST_IP: begin
          local_err_d = (din != cfg_ip_local);
          sum_err_d   = !csum_ok_s;
        end
        default:      type_err_d = type_err_q;
      endcase
      if (din_eop) begin
        len_err_d = (bytes_s != tot_len_s);
      end else begin
        len_err_d = len_err_q;
      end
    end else begin
      len_err_d = len_err_q;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      tot_len_q   <= 16'd0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_sop_q  <= 1'b0;
      dout_eop_q  <= 1'b0;
      dout_mty_q  <= 2'd0;
      type_err_q  <= 1'b0;
      len_err_q   <= 1'b0;
      sum_err_q   <= 1'b0;
      local_err_q <= 1'b0;
      pc_err_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tot_len_q   <= tot_len_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      dout_sop_q  <= dout_sop_d;
      dout_eop_q  <= dout_eop_d;
      dout_mty_q  <= dout_mty_d;
      type_err_q  <= type_err_d;
      len_err_q   <= len_err_d;
      sum_err_q   <= sum_err_d;
      local_err_q <= local_err_d;
      pc_err_q    <= pc_err_d;
    end
  end

  assign dout              = dout_q;
  assign dout_vld          = dout_vld_q;
  assign dout_sop          = dout_sop_q;
  assign dout_eop          = dout_eop_q;
  assign dout_mty          = dout_mty_q;
  assign flag_type_err     = type_err_q;
  assign flag_len_err      = len_err_q;
  assign flag_sum_err      = sum_err_q;
  assign flag_ip_local_err = local_err_q;
  assign flag_ip_pc_err    = pc_err_q;

endmodule

// File: tb/tb_rx_ip_analy.sv
// Self-checking bench for rx_ip_analy: table of packets with hand-computed
// flags, checked every cycle against a small timing model.
module tb_rx_ip_analy;

  logic        clk;
  logic        rst_n;
  logic [31:0] cfg_ip_local;
  logic [31:0] cfg_ip_pc;
  logic [31:0] din;
  logic        din_vld;
  logic        din_sop;
  logic        din_eop;
  logic [1:0]  din_mty;
  logic [31:0] dout;
  logic        dout_vld;
  logic        dout_sop;
  logic        dout_eop;
  logic [1:0]  dout_mty;
  logic        flag_type_err;
  logic        flag_len_err;
  logic        flag_sum_err;
  logic        flag_ip_local_err;
  logic        flag_ip_pc_err;

  rx_ip_analy dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg_ip_local      (cfg_ip_local),
    .cfg_ip_pc         (cfg_ip_pc),
    .din               (din),
    .din_vld           (din_vld),
    .din_sop           (din_sop),
    .din_eop           (din_eop),
    .din_mty           (din_mty),
    .dout              (dout),
    .dout_vld          (dout_vld),
    .dout_sop          (dout_sop),
    .dout_eop          (dout_eop),
    .dout_mty          (dout_mty),
    .flag_type_err     (flag_type_err),
    .flag_len_err      (flag_len_err),
    .flag_sum_err      (flag_sum_err),
    .flag_ip_local_err (flag_ip_local_err),
    .flag_ip_pc_err    (flag_ip_pc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] w0;
    logic [31:0] w2;
    logic [31:0] w3;
    logic [31:0] w4;
    logic [1:0]  mty;
    logic        e_type;
    logic        e_len;
    logic        e_sum;
    logic        e_local;
    logic        e_pc;
  } pkt_t;

  logic [31:0] payload [9];
  pkt_t        tbl [6];

  int n_cmp = 0;
  int n_err = 0;

  // timing model state
  logic        m_type, m_len, m_sum, m_local, m_pc;
  logic [31:0] last_dout;
  logic        pv;
  int          pidx;
  logic [31:0] pdata;
  logic        peop;
  logic [1:0]  pmty;
  pkt_t        pp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_type = 1'b0; m_len = 1'b0; m_sum = 1'b0; m_local = 1'b0; m_pc = 1'b0;
    last_dout = 32'd0;
    pv = 1'b0; pidx = 0; pdata = 32'd0; peop = 1'b0; pmty = 2'd0;
  endtask

  task automatic chk_all_zero();
    chk("rst_dout", dout, 32'd0);
    chk("rst_vld", {31'd0, dout_vld}, 32'd0);
    chk("rst_sop_eop_mty", {28'd0, dout_sop, dout_eop, dout_mty}, 32'd0);
    chk("rst_flags", {27'd0, flag_type_err, flag_len_err, flag_sum_err,
                      flag_ip_local_err, flag_ip_pc_err}, 32'd0);
  endtask

  // outputs now reflect the word driven in the previous cycle
  task automatic check_cycle();
    if (pv) begin
      if (pidx == 0) m_type = pp.e_type;
      if (pidx == 3) m_pc = pp.e_pc;
      if (pidx == 4) begin
        m_local = pp.e_local;
        m_sum   = pp.e_sum;
      end
      if (peop) m_len = pp.e_len;
    end
    if (pv && pidx >= 5) begin
      chk("dout_vld", {31'd0, dout_vld}, 32'd1);
      chk("dout", dout, pdata);
      chk("dout_sop", {31'd0, dout_sop}, {31'd0, (pidx == 5)});
      chk("dout_eop", {31'd0, dout_eop}, {31'd0, peop});
      chk("dout_mty", {30'd0, dout_mty}, peop ? {30'd0, pmty} : 32'd0);
      last_dout = pdata;
    end else begin
      chk("dout_vld_idle", {31'd0, dout_vld}, 32'd0);
      chk("dout_hold", dout, last_dout);
    end
    chk("flag_type_err", {31'd0, flag_type_err}, {31'd0, m_type});
    chk("flag_len_err", {31'd0, flag_len_err}, {31'd0, m_len});
    chk("flag_sum_err", {31'd0, flag_sum_err}, {31'd0, m_sum});
    chk("flag_ip_local_err", {31'd0, flag_ip_local_err}, {31'd0, m_local});
    chk("flag_ip_pc_err", {31'd0, flag_ip_pc_err}, {31'd0, m_pc});
  endtask

  task automatic drive_idle();
    @(posedge clk);
    #1;
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_mty = 2'd0;
    @(negedge clk);
    check_cycle();
    pv = 1'b0;
  endtask

  task automatic drive_word(input pkt_t p, input int i, input logic eop);
    logic [31:0] w;
    case (i)
      0: w = p.w0;
      1: w = 32'h00004000;
      2: w = p.w2;
      3: w = p.w3;
      4: w = p.w4;
      default: w = payload[i-5];
    endcase
    @(posedge clk);
    #1;
    din = w; din_vld = 1'b1; din_sop = (i == 0); din_eop = eop;
    din_mty = eop ? p.mty : 2'd0;
    @(negedge clk);
    check_cycle();
    pv = 1'b1; pidx = i; pdata = w; peop = eop; pmty = din_mty; pp = p;
  endtask

  task automatic send_pkt(input pkt_t p, input int nwords, input logic eop_last,
                          input int gap_a, input int gap_b);
    for (int i = 0; i < nwords; i++) begin
      if (i == gap_a || i == gap_b) drive_idle();
      drive_word(p, i, eop_last && (i == nwords - 1));
    end
    drive_idle();
  endtask

  initial begin
    pkt_t sp;
    payload[0] = 32'h0BB81388; payload[1] = 32'h00245CFA;
    for (int k = 2; k < 8; k++) payload[k] = 32'h00000001;
    payload[8] = 32'h00000002;

    //          name     w0            w2            w3            w4            mty   type  len   sum   loc   pc
    tbl[0] = '{"good",  32'h45000036, 32'hFF11F852, 32'hC0A80109, 32'hC0A8010A, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{"len",   32'h45000039, 32'hFF11F84F, 32'hC0A80109, 32'hC0A8010A, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{"type",  32'h35000038, 32'hFF11F851, 32'hC0A80109, 32'hC0A8010A, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{"sum",   32'h45000038, 32'hFF11F851, 32'hC0A80109, 32'hC0A8010A, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{"local", 32'h45000036, 32'hFF11F854, 32'hC0A80109, 32'hC0A80108, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{"pc",    32'h45000036, 32'hFF11F854, 32'hC0A80107, 32'hC0A8010A, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    cfg_ip_local = 32'hC0A8010A;
    cfg_ip_pc    = 32'hC0A80109;
    din = 32'd0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_mty = 2'd0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero();
    @(negedge clk);
    rst_n = 1'b1;

    // main table, back-to-back with one idle cycle between packets
    for (int t = 0; t < 6; t++) begin
      send_pkt(tbl[t], 14, 1'b1, -1, -1);
    end

    // pc flag held after the stream ends
    repeat (5) drive_idle();

    // reset in the middle of the payload, then a clean packet
    send_pkt(tbl[5], 9, 1'b0, -1, -1);
    #2;
    rst_n = 1'b0;
    din_vld = 1'b0;
    #1;
    chk_all_zero();
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    send_pkt(tbl[0], 14, 1'b1, -1, -1);

    // input gaps in header and payload propagate as output gaps
    send_pkt(tbl[4], 14, 1'b1, 2, 8);
    send_pkt(tbl[0], 14, 1'b1, 6, -1);

    // short packet ending inside the header: no payload output
    sp = tbl[0];
    sp.name = "short";
    sp.w0 = 32'h45000010;
    sp.mty = 2'd0;
    send_pkt(sp, 4, 1'b1, -1, -1);

    // sop mid-packet restarts the count
    send_pkt(tbl[1], 7, 1'b0, -1, -1);
    send_pkt(tbl[2], 14, 1'b1, -1, -1);
    send_pkt(tbl[0], 14, 1'b1, -1, -1);
    repeat (2) drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rx_ip_analy.md
# rx_ip_analy

Receive-side IPv4 header analyser in the UDP/IP stack, between the MAC/Ethernet de-framer and the UDP parser. It accepts an IPv4 packet as a 32-bit word stream with sop/eop/mty framing, strips the 5-word IP header, forwards the payload (UDP header plus data) with one cycle of latency, and raises per-packet error flags for header type, total length, header checksum, destination IP and source IP. Packets are always forwarded; downstream logic uses the flags to decide whether to discard a packet.

## Interface
- DATA_W, 32, stream and IP address width (fixed 32).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_ip_local  in  32  local IP address; compared with the destination field.
- cfg_ip_pc  in  32  peer (PC) IP address; compared with the source field.
- din  in  32  packet word; first byte in [31:24].
- din_vld  in  1  word valid.
- din_sop  in  1  first word of packet (qualified by din_vld).
- din_eop  in  1  last word of packet (qualified by din_vld).
- din_mty  in  2  number of empty low-order bytes in the eop word.
- dout  out  32  payload word.
- dout_vld  out  1  payload word valid.
- dout_sop  out  1  first payload word (input word index 5).
- dout_eop  out  1  last payload word.
- dout_mty  out  2  empty bytes in the dout_eop word.
- flag_type_err  out  1  version != 4 or IHL != 5.
- flag_len_err  out  1  Total Length != received byte count.
- flag_sum_err  out  1  header checksum invalid.
- flag_ip_local_err  out  1  destination IP != cfg_ip_local.
- flag_ip_pc_err  out  1  source IP != cfg_ip_pc.

## Operation
- Word counter:
  - Set to 1 on din_vld&&din_sop, so the sop word is index 0.
  - Otherwise increments on each din_vld word, saturating at 15.
  - din_sop mid-packet restarts the count at 0 for the new packet.
- Header fields by word index:
  - Word 0: version [31:28], IHL [27:24], total length [15:0].
  - Word 2: protocol [23:16].
  - Word 3: source IP.
  - Word 4: destination IP.
- Words with index ≥5 are forwarded: dout<=din; dout_vld<=1; dout_sop<=(index==5); dout_eop<=din_eop; dout_mty<=din_eop?din_mty:0.
- A packet whose eop falls at index ≤4 produces no output.
- Header stripping is always exactly 5 words, even when IHL != 5.
- Checksum: 17-bit one's-complement accumulation of the ten 16-bit halfwords of words 0–4, with end-around carry. The header is valid iff the final sum == 16'hFFFF.
- Length check: bytes = 4×(index+1) − din_mty at the eop word; error iff bytes != total length.
- Flags:
  - Each flag is registered and updated only when its deciding word arrives.
  - Each flag holds its value until the next packet updates it.
  - Flags are not cleared by sop.
- cfg_ip_* are sampled on the word being compared.

## Timing
Input sop word at cycle T with contiguous valid words:
- flag_type_err updates at T+1.
- flag_ip_pc_err updates at T+4.
- flag_ip_local_err and flag_sum_err update at T+5.
- dout_sop at T+6; each payload word appears 1 cycle after its input word.
- flag_len_err updates in the same cycle as dout_eop.

Other timing rules:
- din_vld gaps propagate as dout_vld gaps; dout holds its last value when dout_vld=0.
- No backpressure.
- Reset: all outputs and the counter are 0, the accumulator is cleared, and any in-flight packet is dropped. The next din_sop starts cleanly.

## Configuration
- RX_IP_PROTO_CHK_EN defined: flag_type_err additionally asserts when protocol != 8'h11 (UDP). The type flag is then re-evaluated at T+3, OR-ed with the word-0 result.
- RX_IP_PROTO_CHK_EN undefined: the protocol field is ignored.

## Structure
- Package rx_ip_pkg:
  - IP_VERSION=4, IP_IHL=5, IP_HDR_WORDS=5.
  - IP_PROTO_UDP=8'h11, CSUM_OK=16'hFFFF.
  - Word-index constants for the header fields.
- Sub-module ip_hdr_csum: one's-complement 16-bit accumulator with clear-on-sop, add of two halfwords per word, and an ok output.

## Test plan
cfg_ip_local=C0A8010A, cfg_ip_pc=C0A80109; every packet is 14 words long, with payload 0BB81388, 00245CFA, 00000001×6, 00000002.
- Good packet: header 45000036/00004000/FF11F852/C0A80109/C0A8010A, mty=2 -> 9 payload words at T+6..T+14, sop at 0BB81388, eop word 00000002 with mty=2; all flags 0.
- Length error: word 0 = 45000039, checksum F84F, mty=3 -> payload forwarded with dout_mty=3; flag_len_err=1 at dout_eop; flag_sum_err=0.
- Type error: word 0 = 35000038, checksum F851 -> flag_type_err=1 from T+1 through the next packet's T+1; flag_sum_err=1 from T+5.
- Checksum error: 45000038 with checksum F851 (correct value F850) -> flag_sum_err=1 from T+5; flag_type_err cleared at T+1.
- IP errors: destination C0A80108 -> flag_ip_local_err=1 at T+5. Next packet with source C0A80107 -> flag_ip_pc_err=1 at T+4 and held after the stream ends.
- Reset asserted mid-payload -> all outputs 0 immediately; the next good packet is forwarded correctly.
